// File: rtl/rps_referee.sv
// Rock-paper-scissors round referee: requests the AI move, takes the player move, scores, keeps totals.
// Optional predictor timeout with mod-3 fallback move when RPS_PRED_TIMEOUT_EN is defined.
module rps_referee #(
  parameter int ROUNDS  = 60,
  parameter int ROUND_W = 6,
  parameter int SCORE_W = 7,
  parameter int TIMEOUT = 1023
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         player_move,
  input  logic               move_valid,
  input  logic               new_game,
  output logic               pred_req,
  input  logic               pred_ack,
  input  logic [1:0]         pred_choice,
  output logic [1:0]         ai_move,
  output logic [3:0]         combination,
  output logic               comb_valid,
  output logic [7:0]         reward,
  output logic [1:0]         outcome,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] ai_score,
  output logic [SCORE_W-1:0] tie_count,
  output logic [ROUND_W-1:0] round_count,
  output logic               awaiting_move,
  output logic               game_over,
  output logic               illegal_move,
  output logic               pred_timeout
);

  typedef enum logic [2:0] {S_REQ, S_WAIT_PRED, S_WAIT_PLAYER, S_SCORE, S_DONE} state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [SCORE_W-1:0] SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};
  localparam logic [ROUND_W-1:0] ROUND_ONE = {{(ROUND_W-1){1'b0}}, 1'b1};
  localparam logic [ROUND_W-1:0] ROUND_END = ROUND_W'(ROUNDS);

  if (TIMEOUT < 1 || ROUNDS < 1 || ROUNDS >= (1 << ROUND_W)) begin : g_bad_cfg
    $error("rps_referee: ROUNDS must fit ROUND_W and TIMEOUT must be positive");
  end

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == SCORE_MAX) ? v : v + SCORE_ONE;
  endfunction

  // Move that beats m: rock(0) < paper(1) < scissors(2) < rock.
  function automatic logic [1:0] beats(input logic [1:0] m);
    case (m)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  state_t             r_state;
  logic               r_phase;
  logic [1:0]         r_player;
  logic               r_ai_win;
  logic               r_pl_win;
  logic               r_pred_req;
  logic [1:0]         r_ai_move;
  logic [3:0]         r_comb;
  logic               r_comb_vld;
  logic [7:0]         r_reward;
  logic [1:0]         r_outcome;
  logic [SCORE_W-1:0] r_pl_score;
  logic [SCORE_W-1:0] r_ai_score;
  logic [SCORE_W-1:0] r_ties;
  logic [ROUND_W-1:0] r_round;
  logic               r_await;
  logic               r_over;
  logic               r_illegal;
  logic               r_tmo_pulse;
  logic               w_tmo;
  logic [1:0]         w_fallback;
  logic [ROUND_W-1:0] w_round_nx;

  assign w_round_nx = r_round + ROUND_ONE;

`ifdef RPS_PRED_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

  logic [TMO_W-1:0] r_tmo_cnt;
  logic [1:0]       r_mod3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
      r_mod3    <= 2'd0;
    end else begin
      r_mod3    <= beats(r_mod3);
      r_tmo_cnt <= (r_state == S_WAIT_PRED) ? r_tmo_cnt + TMO_ONE : '0;
    end
  end

  assign w_tmo      = (r_state == S_WAIT_PRED) && (r_tmo_cnt == TMO_LAST);
  assign w_fallback = r_mod3;
`else
  assign w_tmo      = 1'b0;
  assign w_fallback = 2'd0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_REQ;
      r_phase     <= 1'b0;
      r_player    <= 2'd0;
      r_ai_win    <= 1'b0;
      r_pl_win    <= 1'b0;
      r_pred_req  <= 1'b0;
      r_ai_move   <= 2'd0;
      r_comb      <= 4'd0;
      r_comb_vld  <= 1'b0;
      r_reward    <= 8'd0;
      r_outcome   <= 2'd0;
      r_pl_score  <= '0;
      r_ai_score  <= '0;
      r_ties      <= '0;
      r_round     <= '0;
      r_await     <= 1'b0;
      r_over      <= 1'b0;
      r_illegal   <= 1'b0;
      r_tmo_pulse <= 1'b0;
    end else begin
      r_comb_vld  <= 1'b0;
      r_illegal   <= 1'b0;
      r_tmo_pulse <= 1'b0;
      if (new_game) begin
        r_state    <= S_REQ;
        r_phase    <= 1'b0;
        r_pred_req <= 1'b0;
        r_ai_move  <= 2'd0;
        r_comb     <= 4'd0;
        r_reward   <= 8'd0;
        r_outcome  <= 2'd0;
        r_pl_score <= '0;
        r_ai_score <= '0;
        r_ties     <= '0;
        r_round    <= '0;
        r_await    <= 1'b0;
        r_over     <= 1'b0;
      end else begin
        case (r_state)
          S_REQ: begin
            r_pred_req <= 1'b1;
            r_state    <= S_WAIT_PRED;
          end
          S_WAIT_PRED: begin
            if (pred_ack || w_tmo) begin
              r_ai_move   <= pred_ack ? ((pred_choice == 2'd3) ? 2'd0 : pred_choice) : w_fallback;
              r_tmo_pulse <= !pred_ack;
              r_pred_req  <= 1'b0;
              r_await     <= 1'b1;
              r_state     <= S_WAIT_PLAYER;
            end
          end
          S_WAIT_PLAYER: begin
            if (move_valid && player_move == 2'd3) begin
              r_illegal <= 1'b1;
            end else if (move_valid) begin
              r_player <= player_move;
              r_await  <= 1'b0;
              r_phase  <= 1'b0;
              r_state  <= S_SCORE;
            end
          end
          S_SCORE: begin
            // First cycle resolves the winner, second cycle commits the round.
            if (!r_phase) begin
              r_ai_win <= (r_ai_move == beats(r_player));
              r_pl_win <= (r_player == beats(r_ai_move));
              r_phase  <= 1'b1;
            end else begin
              r_phase    <= 1'b0;
              r_comb_vld <= 1'b1;
              r_comb     <= {r_ai_move, r_player};
              r_round    <= w_round_nx;
              if (r_ai_win) begin
                r_ai_score <= sat_inc(r_ai_score);
                r_outcome  <= 2'd2;
                r_reward   <= 8'h01;
              end else if (r_pl_win) begin
                r_pl_score <= sat_inc(r_pl_score);
                r_outcome  <= 2'd1;
                r_reward   <= 8'hFF;
              end else begin
                r_ties     <= sat_inc(r_ties);
                r_outcome  <= 2'd3;
                r_reward   <= 8'h00;
              end
              if (w_round_nx == ROUND_END) begin
                r_over  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_state <= S_REQ;
              end
            end
          end
          default: r_state <= S_DONE;
        endcase
      end
    end
  end

  assign pred_req      = r_pred_req;
  assign ai_move       = r_ai_move;
  assign combination   = r_comb;
  assign comb_valid    = r_comb_vld;
  assign reward        = r_reward;
  assign outcome       = r_outcome;
  assign player_score  = r_pl_score;
  assign ai_score      = r_ai_score;
  assign tie_count     = r_ties;
  assign round_count   = r_round;
  assign awaiting_move = r_await;
  assign game_over     = r_over;
  assign illegal_move  = r_illegal;
  assign pred_timeout  = r_tmo_pulse;

endmodule

// File: tb/tb_rps_referee.sv
// Directed bench for rps_referee: scoring, illegal moves, game end, new_game, reset, timeout.
module tb_rps_referee;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] player_move = 2'd0;
  logic       move_valid = 1'b0;
  logic       new_game = 1'b0;
  logic       pred_req;
  logic       pred_ack = 1'b0;
  logic [1:0] pred_choice = 2'd0;
  logic [1:0] ai_move;
  logic [3:0] combination;
  logic       comb_valid;
  logic [7:0] reward;
  logic [1:0] outcome;
  logic [6:0] player_score, ai_score, tie_count;
  logic [5:0] round_count;
  logic       awaiting_move, game_over, illegal_move, pred_timeout;

  int n_vec = 0;
  int n_err = 0;

  rps_referee #(.ROUNDS(60), .ROUND_W(6), .SCORE_W(7), .TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .player_move(player_move), .move_valid(move_valid),
    .new_game(new_game), .pred_req(pred_req), .pred_ack(pred_ack), .pred_choice(pred_choice),
    .ai_move(ai_move), .combination(combination), .comb_valid(comb_valid), .reward(reward),
    .outcome(outcome), .player_score(player_score), .ai_score(ai_score), .tie_count(tie_count),
    .round_count(round_count), .awaiting_move(awaiting_move), .game_over(game_over),
    .illegal_move(illegal_move), .pred_timeout(pred_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (pred_req) break;
      tick();
    end
    chk("pred_req_wait", pred_req, 1);
  endtask

  task automatic ack(input logic [1:0] c);
    pred_ack = 1'b1; pred_choice = c;
    tick();
    pred_ack = 1'b0;
  endtask

  task automatic move(input logic [1:0] p);
    move_valid = 1'b1; player_move = p;
    tick();
    move_valid = 1'b0;
  endtask

  task automatic play(input logic [1:0] c, input logic [1:0] p);
    wait_req();
    ack(c);
    move(p);
    tick();
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_pred_req", pred_req, 0);
    chk("rst_ai_move", ai_move, 0);
    chk("rst_round", round_count, 0);
    chk("rst_await", awaiting_move, 0);
    chk("rst_over", game_over, 0);
    reset = 1'b1;
    tick();
    chk("first_req", pred_req, 1);

    // Round 1: AI paper beats player rock
    wait_req(); ack(2'd1);
    chk("r1_ai", ai_move, 1);
    chk("r1_await", awaiting_move, 1);
    move(2'd0);
    tick();
    chk("r1_early_cv", comb_valid, 0);
    tick();
    chk("r1_cv", comb_valid, 1);
    chk("r1_outcome", outcome, 2);
    chk("r1_reward", reward, 8'h01);
    chk("r1_comb", combination, 4'b0100);
    chk("r1_ai_score", ai_score, 1);
    chk("r1_round", round_count, 1);
    tick();
    chk("r1_cv_off", comb_valid, 0);
    chk("r1_next_req", pred_req, 1);

    // Round 2: player paper beats AI rock; round 3: tie
    play(2'd0, 2'd1);
    chk("r2_outcome", outcome, 1);
    chk("r2_reward", reward, 8'hFF);
    chk("r2_pl_score", player_score, 1);
    chk("r2_comb", combination, 4'b0001);
    tick();
    play(2'd2, 2'd2);
    chk("r3_outcome", outcome, 3);
    chk("r3_reward", reward, 8'h00);
    chk("r3_ties", tie_count, 1);
    tick();

    // Round 4: predictor code 3 becomes rock, beats scissors
    wait_req(); ack(2'd3);
    chk("r4_coerce", ai_move, 0);
    move(2'd2); tick(); tick();
    chk("r4_outcome", outcome, 2);
    chk("r4_ai_score", ai_score, 2);
    tick();

    // Round 5: stray strobes, illegal move, then a tie
    wait_req();
    move(2'd0);
    chk("stray_mv_round", round_count, 4);
    ack(2'd1);
    ack(2'd2);
    chk("stray_ack_ai", ai_move, 1);
    chk("r5_await", awaiting_move, 1);
    move(2'd3);
    chk("ill_pulse", illegal_move, 1);
    chk("ill_await", awaiting_move, 1);
    tick();
    chk("ill_off", illegal_move, 0);
    chk("ill_no_cv", comb_valid, 0);
    chk("ill_round", round_count, 4);
    move(2'd1); tick(); tick();
    chk("r5_cv", comb_valid, 1);
    chk("r5_outcome", outcome, 3);
    chk("r5_ties", tie_count, 2);
    chk("r5_comb", combination, 4'b0101);
    tick();

    // Rounds 6..60: player always plays the move beating the AI
    for (int i = 6; i <= 60; i++) begin
      logic [1:0] c;
      c = 2'(i % 3);
      play(c, 2'((i + 1) % 3));
      chk("loop_cv", comb_valid, 1);
      chk("loop_outcome", outcome, 1);
      chk("loop_over", game_over, (i == 60));
      tick();
    end
    chk("end_round", round_count, 60);
    chk("end_pl_score", player_score, 56);
    chk("end_ai_score", ai_score, 2);
    chk("end_ties", tie_count, 2);

    // DONE ignores strobes
    pred_ack = 1'b1; move_valid = 1'b1; player_move = 2'd0;
    tick();
    pred_ack = 1'b0; move_valid = 1'b0;
    tick(); tick(); tick();
    chk("done_round", round_count, 60);
    chk("done_cv", comb_valid, 0);
    chk("done_req", pred_req, 0);
    chk("done_over", game_over, 1);

    // new_game clears everything
    new_game = 1'b1; tick(); new_game = 1'b0;
    chk("ng_round", round_count, 0);
    chk("ng_pl_score", player_score, 0);
    chk("ng_over", game_over, 0);
    chk("ng_outcome", outcome, 0);
    chk("ng_comb", combination, 0);
    tick();
    chk("ng_req", pred_req, 1);

    // new_game wins over a simultaneous move
    play(2'd1, 2'd0);
    chk("ng2_ai_score", ai_score, 1);
    tick();
    wait_req(); ack(2'd2);
    move_valid = 1'b1; new_game = 1'b1; player_move = 2'd0;
    tick();
    move_valid = 1'b0; new_game = 1'b0;
    chk("ngmv_round", round_count, 0);
    chk("ngmv_ai_score", ai_score, 0);
    chk("ngmv_ai", ai_move, 0);
    chk("ngmv_await", awaiting_move, 0);
    tick(); tick();
    chk("ngmv_no_cv", comb_valid, 0);

    // Reset asserted while scoring
    wait_req(); ack(2'd1); move(2'd0);
    reset = 1'b0;
    #1;
    chk("rstmid_ai", ai_move, 0);
    chk("rstmid_req", pred_req, 0);
    chk("rstmid_cv", comb_valid, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("rstmid_resume", pred_req, 1);
    chk("rstmid_round", round_count, 0);

`ifdef RPS_PRED_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_early", pred_timeout, 0);
    chk("tmo_early_await", awaiting_move, 0);
    tick();
    chk("tmo_pulse", pred_timeout, 1);
    chk("tmo_await", awaiting_move, 1);
    chk("tmo_ai_range", (ai_move <= 2'd2), 1);
    tick();
    chk("tmo_off", pred_timeout, 0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("no_tmo", pred_timeout, 0);
    chk("no_tmo_req", pred_req, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rps_referee.md
Name: rps_referee

Overview:
- Round controller that drives the move-predictor interface from the game side.
- Each round it requests the AI's move from the predictor and commits it before the player's move is accepted.
- It then scores the round and publishes the {AI, player} combination code and a signed reward back to the learner.
- It keeps scores and a round count, and ends the game after a fixed number of rounds.

Parameters:
- ROUNDS, 60: rounds per game.
- ROUND_W, 6: width of round_count; must hold ROUNDS.
- SCORE_W, 7: width of each score counter.
- TIMEOUT, 1023: predictor wait limit in cycles; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- player_move  in  2  player move: 0 rock, 1 paper, 2 scissors, 3 illegal.
- move_valid  in  1  single-cycle strobe; player_move is valid in that cycle.
- new_game  in  1  single-cycle strobe; starts a fresh game.
- pred_req  out  1  asserted while the referee waits for a prediction.
- pred_ack  in  1  predictor strobe; pred_choice is valid in that cycle.
- pred_choice  in  2  AI move from the predictor.
- ai_move  out  2  committed AI move for the current round.
- combination  out  4  {ai_move, player_move} of the last scored round.
- comb_valid  out  1  one-cycle strobe: combination, reward and outcome are updated.
- reward  out  8  two's complement, from the AI's side: +1 AI win, -1 AI loss (8'hFF), 0 tie.
- outcome  out  2  0 none, 1 player win, 2 AI win, 3 tie.
- player_score, ai_score, tie_count  out  SCORE_W each  running totals.
- round_count  out  ROUND_W  rounds completed.
- awaiting_move  out  1  high in WAIT_PLAYER.
- game_over  out  1  high in DONE.
- illegal_move  out  1  one-cycle strobe when move_valid carries code 3.
- pred_timeout  out  1  one-cycle strobe when the fallback move is used.

Behaviour:
- Reset values: every output and counter is 0. State is REQ.
- States:
  - REQ: drives pred_req=1; moves to WAIT_PRED on the next edge.
  - WAIT_PRED: pred_req=1. On pred_ack, latch pred_choice into ai_move and go to WAIT_PLAYER. A pred_choice of 3 is coerced to 0.
  - WAIT_PLAYER: pred_req=0, awaiting_move=1. On move_valid with code 0-2, latch the move and go to SCORE. On code 3, pulse illegal_move the next cycle and stay in WAIT_PLAYER.
  - SCORE: compute the result.
    - AI wins iff ai_move == (player+1) mod 3; player wins iff player == (ai_move+1) mod 3; otherwise tie.
    - On the next edge: increment the matching counter, increment round_count, and update outcome, reward and combination.
    - comb_valid=1 for exactly that cycle. Go to DONE if the new round_count == ROUNDS, else to REQ.
  - DONE: game_over=1; ignores move_valid and pred_ack.
- Latency: if move_valid is sampled at edge N, comb_valid is high in the cycle after edge N+2. The next pred_req rises in the cycle after edge N+3.
- move_valid outside WAIT_PLAYER is ignored and never buffered. pred_ack outside WAIT_PRED is ignored.
- new_game in any state clears all counters, outcome, reward, combination and ai_move, and goes to REQ on the next edge.
  - new_game takes priority over a simultaneous move_valid or pred_ack.
  - new_game mid-round aborts the round without scoring.
- Score counters saturate at 2^SCORE_W-1. round_count never exceeds ROUNDS.
- Reset asserted mid-operation forces reset values immediately. Operation resumes in REQ on the first edge after release.
- A single-cycle pred_ack coinciding with entry into WAIT_PRED is accepted only if it is sampled while the state is WAIT_PRED.

Optional Feature:
- Macro: RPS_PRED_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT_PRED.
  - After TIMEOUT cycles without pred_ack, ai_move takes the value of a free-running mod-3 counter (0,1,2,0… every cycle since reset), pred_timeout pulses, and the state goes to WAIT_PLAYER.
  - The counter clears on every WAIT_PRED entry.
- Undefined: WAIT_PRED waits indefinitely, and pred_timeout is tied to 0.

Test Plan:
- After reset, pred_ack with choice 1, then move_valid with player 0 -> ai_move=1, outcome=2, reward=8'h01, combination=4'b0100, ai_score=1, round_count=1, single comb_valid pulse.
- Choice 0 vs player 1 -> outcome=1, reward=8'hFF, player_score=1. Choice 2 vs player 2 -> outcome=3, reward=0, tie_count=1.
- move_valid with player_move=3 in WAIT_PLAYER -> illegal_move pulses once, no comb_valid, state unchanged. A later legal move scores normally.
- Play 60 rounds -> game_over=1 after the 60th comb_valid. Further strobes are ignored. new_game -> all counters 0, pred_req=1 within 1 cycle.
- new_game and move_valid in the same cycle during WAIT_PLAYER -> no scoring, counters cleared. Reset asserted during SCORE -> all outputs 0 immediately.
- With RPS_PRED_TIMEOUT_EN, TIMEOUT=8, pred_ack withheld -> pred_timeout pulses after 8 cycles, ai_move is in 0-2, awaiting_move=1.
